// File: rtl/uart_tx.sv
// uart_tx: 8N1/8N2 UART transmitter draining bytes from a FIFO.
// Ports: clk/rst, en, fifo_data/fifo_empty in; fifo_rd_en, tx, busy, tx_done out.
module uart_tx #(
  parameter int OVERSAMPLE = 32,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] OVS_MAX = CW'(OVERSAMPLE - 1);
  localparam logic          SB_MAX  = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] ovs_q, ovs_d;
  logic          stop_q, stop_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          rd_q, rd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_end;

  assign bit_end = (ovs_q == OVS_MAX);

  always_comb begin
    state_d = state_q;
    ovs_d   = ovs_q;
    stop_d  = stop_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (en && !fifo_empty) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        state_d = S_START;
        shift_d = fifo_data;
        ovs_d   = '0;
      end
      S_START: begin
        ovs_d = bit_end ? '0 : ovs_q + 1'b1;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        ovs_d = bit_end ? '0 : ovs_q + 1'b1;
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        ovs_d = bit_end ? '0 : ovs_q + 1'b1;
        if (bit_end) begin
          if (stop_q == SB_MAX) begin
            stop_d  = 1'b0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so derive them from the next state.
    tx_d = 1'b1;
    if (state_d == S_START) tx_d = 1'b0;
    else if (state_d == S_DATA) tx_d = shift_d[0];
    rd_d   = (state_d == S_FETCH);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ovs_q   <= '0;
      stop_q  <= 1'b0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ovs_q   <= ovs_d;
      stop_q  <= stop_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx         = tx_q;
  assign fifo_rd_en = rd_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed + random frames against a waveform model,
// a FIFO model and a behavioural mid-bit sampling receiver.
module tb_uart_tx;
  localparam int OVS = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] fifo_data = '0;
  logic       fifo_empty = 1'b1;
  logic       fifo_rd_en, tx, busy, tx_done;

  logic       en2 = 1'b0;
  logic       empty2 = 1'b1;
  logic [7:0] data2 = '0;
  logic       rd2, tx2, busy2, done2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int rd_rise = -1;
  int busy_rise = -1;
  int busy_fall = -1;
  int bad_rd = 0;
  int rx_err = 0;
  logic prev_rd = 1'b0;
  logic prev_busy = 1'b0;
  logic [7:0] fq[$];
  logic [7:0] rxq[$];

  uart_tx #(.OVERSAMPLE(OVS), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .en(en),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .tx(tx),
    .busy(busy), .tx_done(tx_done)
  );

  uart_tx #(.OVERSAMPLE(OVS), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .en(en2),
    .fifo_data(data2), .fifo_empty(empty2),
    .fifo_rd_en(rd2), .tx(tx2),
    .busy(busy2), .tx_done(done2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: read data valid the cycle after rd_en is sampled.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fq.size() == 0) bad_rd <= bad_rd + 1;
      else fifo_data <= fq.pop_front();
    end
    fifo_empty <= (fq.size() == 0);
  end

  // One-entry FIFO holding 0x81 for the two-stop-bit instance.
  always @(posedge clk) begin
    if (rd2) begin
      data2  <= 8'h81;
      empty2 <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
    if (fifo_rd_en && !prev_rd) rd_rise <= cyc;
    if (tx_done) done_cnt <= done_cnt + 1;
    if (busy === 1'b1 && !prev_busy) busy_rise <= cyc;
    if (busy === 1'b0 && prev_busy) busy_fall <= cyc;
    prev_rd   <= fifo_rd_en;
    prev_busy <= (busy === 1'b1);
  end

  // Receiver: find the start edge, sample each bit at its centre.
  logic       rxprev = 1'b1;
  logic [7:0] rxb;
  initial begin
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && rxprev === 1'b1) begin
        repeat (OVS / 2) @(negedge clk);
        if (tx !== 1'b0) rx_err++;
        for (int j = 0; j < 8; j++) begin
          repeat (OVS) @(negedge clk);
          rxb[j] = tx;
        end
        repeat (OVS) @(negedge clk);
        if (tx !== 1'b1) rx_err++;
        rxq.push_back(rxb);
        rxprev = 1'b1;
      end else begin
        rxprev = tx;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: no summary before time limit");
    $fatal(1, "timeout");
  end

  function automatic logic txs(input bit sel);
    return sel ? tx2 : tx;
  endfunction

  function automatic logic dones(input bit sel);
    return sel ? done2 : tx_done;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    fifo_empty <= 1'b0;
  endtask

  task automatic wait_fall(input bit sel, output int f);
    f = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (txs(sel) === 1'b0) begin
        f = cyc;
        break;
      end
    end
  endtask

  // Expected line: start 0, eight data bits LSB first, sb stop 1s,
  // each OVS cycles; tx_done on the cycle right after.
  task automatic check_frame(input string tag, input bit sel,
                             input logic [7:0] d, input int sb,
                             input int f, output int done_at);
    int   bad;
    int   len;
    logic e;
    bad = 0;
    len = (9 + sb) * OVS;
    done_at = -1;
    chk({tag, " start"}, 32'(f >= 0), 1);
    if (f >= 0) begin
      for (int k = 0; k < len; k++) begin
        if (k > 0) @(negedge clk);
        if (k < OVS) e = 1'b0;
        else if (k < 9 * OVS) e = d[k / OVS - 1];
        else e = 1'b1;
        if (txs(sel) !== e) bad++;
      end
      @(negedge clk);
      done_at = cyc;
      chk({tag, " bad_cycles"}, bad, 0);
      chk({tag, " done"}, dones(sel), 1);
    end
  endtask

  task automatic run_batch(input string tag, input logic [7:0] q[$]);
    int f;
    int d_at;
    int d_prev;
    int r0;
    r0 = rd_cnt;
    d_prev = -1;
    rxq.delete();
    foreach (q[i]) push(q[i]);
    foreach (q[i]) begin
      wait_fall(0, f);
      if (i > 0)
        chk($sformatf("%s gap%0d", tag, i), f - d_prev, 3);
      check_frame($sformatf("%s f%0d", tag, i), 0, q[i], 1, f, d_at);
      d_prev = d_at;
    end
    repeat (10) @(negedge clk);
    chk({tag, " rd_cnt"}, rd_cnt - r0, q.size());
    chk({tag, " rx_n"}, rxq.size(), q.size());
    foreach (q[i])
      if (i < rxq.size())
        chk($sformatf("%s rx%0d", tag, i), rxq[i], q[i]);
    chk({tag, " rx_err"}, rx_err, 0);
  endtask

  initial begin
    int f;
    int c;
    int d_at;
    int rd0;
    int dc0;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] q[$];

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst tx", tx, 1);
    chk("rst rd_en", fifo_rd_en, 0);
    chk("rst busy", busy, 0);
    chk("rst tx_done", tx_done, 0);
    chk("rst tx2", tx2, 1);

    rst = 1'b0;
    en = 1'b1;
    repeat (100) @(negedge clk);
    chk("empty rd_cnt", rd_cnt, 0);
    chk("empty tx", tx, 1);
    chk("empty busy", busy, 0);

    push(8'hA5);
    wait_fall(0, f);
    check_frame("a5", 0, 8'hA5, 1, f, d_at);
    repeat (5) @(negedge clk);
    chk("a5 rd_cnt", rd_cnt, 1);
    chk("a5 done_cnt", done_cnt, 1);
    chk("a5 rd_to_fall", f - rd_rise, 2);
    chk("a5 rd_through_done", d_at - rd_rise + 1, 323);
    chk("a5 busy_rise", busy_rise, rd_rise);
    chk("a5 busy_fall", busy_fall, d_at);

    q = {8'h00, 8'hFF, 8'h3C};
    run_batch("trio", q);

    q.delete();
    for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
    run_batch("rand", q);

    ra = 8'($urandom);
    rb = 8'($urandom);
    rd0 = rd_cnt;
    push(ra);
    push(rb);
    wait_fall(0, f);
    fork
      begin
        repeat (100) @(negedge clk);
        en = 1'b0;
      end
    join_none
    check_frame("en_a", 0, ra, 1, f, d_at);
    repeat (400) @(negedge clk);
    chk("en_off rd_cnt", rd_cnt - rd0, 1);
    chk("en_off fifo_left", fq.size(), 1);
    chk("en_off tx", tx, 1);
    c = cyc;
    en = 1'b1;
    wait_fall(0, f);
    chk("en_on latency", f - c, 3);
    check_frame("en_b", 0, rb, 1, f, d_at);

    empty2 <= 1'b0;
    en2 = 1'b1;
    wait_fall(1, f);
    check_frame("sb2", 1, 8'h81, 2, f, d_at);
    chk("sb2 len", d_at - f, 352);
    en2 = 1'b0;

    repeat (10) @(negedge clk);
    ra = 8'($urandom);
    rb = 8'($urandom);
    dc0 = done_cnt;
    push(ra);
    push(rb);
    wait_fall(0, f);
    repeat (5 * OVS + 10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort tx", tx, 1);
    chk("abort busy", busy, 0);
    chk("abort done", tx_done, 0);
    repeat (320) @(negedge clk);
    chk("abort no_done", done_cnt, dc0);
    rst = 1'b0;
    rxq.delete();
    wait_fall(0, f);
    check_frame("after_rst", 0, rb, 1, f, d_at);
    repeat (10) @(negedge clk);
    chk("after_rst rx_n", rxq.size(), 1);
    if (rxq.size() > 0) chk("after_rst rx", rxq[0], rb);
    chk("after_rst done_cnt", done_cnt - dc0, 1);
    chk("fifo_empty reads", bad_rd, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
